// File: rtl/wb_commit_v.sv
// ---------------------------------------------------------------------------
// wb_commit_v -- write-back commit buffer
//
// Write-back tokens from an execution unit are queued in a DEPTH-entry FIFO.
// Each token carries one element of a vector slice. A three-state FSM
// (IDLE / WRITE / COMMIT) drains the FIFO into the register file one element
// per accepted write. When every element of a slice has been written, or when
// an element with a different issue number arrives while a slice is still
// incomplete, the FSM spends one cycle in COMMIT and pulses O_Commit with the
// issue number of the slice that finished.
//
// Ports
//   clock           : sole clock, all state updates on its rising edge
//   reset           : asynchronous active-low reset
//   I_WB_Valid      : write-back token valid
//   I_WB_Issue_No   : issue number of the token
//   I_WB_Dst_Idx    : destination base register index of the slice
//   I_WB_Slice_Len  : element count of the slice (0 is treated as 1)
//   I_WB_Data       : element data
//   I_RF_Ready      : register file accepts a write this cycle
//   O_Full          : FIFO full, upstream must stall
//   O_RF_We         : register-file write enable
//   O_RF_Idx        : register-file write index
//   O_RF_Data       : register-file write data
//   O_Commit        : one-cycle pulse, slice fully written
//   O_Commit_No     : issue number being committed
//   O_Busy          : FIFO non-empty, slice in progress or FSM not idle
// ---------------------------------------------------------------------------
module wb_commit_v #(
    parameter int unsigned WIDTH_DATA  = 32,
    parameter int unsigned WIDTH_ISSUE = 7,
    parameter int unsigned WIDTH_IDX   = 6,
    parameter int unsigned WIDTH_LEN   = 6,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   I_WB_Valid,
    input  logic [WIDTH_ISSUE-1:0] I_WB_Issue_No,
    input  logic [WIDTH_IDX-1:0]   I_WB_Dst_Idx,
    input  logic [WIDTH_LEN-1:0]   I_WB_Slice_Len,
    input  logic [WIDTH_DATA-1:0]  I_WB_Data,
    input  logic                   I_RF_Ready,
    output logic                   O_Full,
    output logic                   O_RF_We,
    output logic [WIDTH_IDX-1:0]   O_RF_Idx,
    output logic [WIDTH_DATA-1:0]  O_RF_Data,
    output logic                   O_Commit,
    output logic [WIDTH_ISSUE-1:0] O_Commit_No,
    output logic                   O_Busy
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = WIDTH_ISSUE + WIDTH_IDX + WIDTH_LEN + WIDTH_DATA;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Registered state
    state_e                 state_q,     state_d;
    logic [PTR_W-1:0]       wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]       count_q,     count_d;
    logic [WIDTH_LEN-1:0]   elem_cnt_q,  elem_cnt_d;
    logic [WIDTH_ISSUE-1:0] cur_issue_q, cur_issue_d;
    logic [WIDTH_ISSUE-1:0] commit_no_q, commit_no_d;
    logic [ENTRY_W-1:0]     mem_q [DEPTH];

    // Combinational helpers
    logic                   full_s;
    logic                   empty_s;
    logic                   push_s;
    logic                   pop_s;
    logic [ENTRY_W-1:0]     wb_entry_s;
    logic [ENTRY_W-1:0]     head_s;
    logic [WIDTH_ISSUE-1:0] head_issue_s;
    logic [WIDTH_IDX-1:0]   head_idx_s;
    logic [WIDTH_LEN-1:0]   head_len_s;
    logic [WIDTH_DATA-1:0]  head_data_s;
    logic [WIDTH_LEN-1:0]   eff_len_s;
    logic [WIDTH_LEN-1:0]   elem_inc_s;
    logic                   we_s;
    logic [WIDTH_IDX-1:0]   idx_s;
    logic [WIDTH_DATA-1:0]  data_s;

    assign full_s     = (count_q == CNT_W'(DEPTH));
    assign empty_s    = (count_q == {CNT_W{1'b0}});
    // Tokens offered while full are dropped on purpose: upstream must stall.
    assign push_s     = I_WB_Valid & ~full_s;
    assign pop_s      = we_s & I_RF_Ready;
    assign wb_entry_s = {I_WB_Issue_No, I_WB_Dst_Idx, I_WB_Slice_Len, I_WB_Data};
    assign elem_inc_s = elem_cnt_q + {{(WIDTH_LEN-1){1'b0}}, 1'b1};

    // Unpack the FIFO head entry and derive its effective slice length.
    always_comb begin
        head_s       = mem_q[rd_ptr_q];
        head_issue_s = head_s[ENTRY_W-1 -: WIDTH_ISSUE];
        head_idx_s   = head_s[WIDTH_LEN+WIDTH_DATA +: WIDTH_IDX];
        head_len_s   = head_s[WIDTH_DATA +: WIDTH_LEN];
        head_data_s  = head_s[WIDTH_DATA-1:0];
        if (head_len_s == {WIDTH_LEN{1'b0}}) begin
            eff_len_s = {{(WIDTH_LEN-1){1'b0}}, 1'b1};
        end else begin
            eff_len_s = head_len_s;
        end
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (pop_s && !push_s) begin
            count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // FSM next-state, slice tracking and register-file write outputs.
    always_comb begin
        state_d     = state_q;
        elem_cnt_d  = elem_cnt_q;
        cur_issue_d = cur_issue_q;
        commit_no_d = commit_no_q;
        we_s        = 1'b0;
        idx_s       = {WIDTH_IDX{1'b0}};
        data_s      = {WIDTH_DATA{1'b0}};
        case (state_q)
            ST_IDLE: begin
                // Looking at the incoming push gives a one-cycle push-to-write path.
                if (!empty_s || push_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (empty_s) begin
                    // A partial slice keeps the FSM in WRITE waiting for its next element.
                    if ((elem_cnt_q == {WIDTH_LEN{1'b0}}) && !push_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else if ((elem_cnt_q != {WIDTH_LEN{1'b0}}) && (head_issue_s != cur_issue_q)) begin
                    // New issue number mid-slice: close the old slice without writing
                    // the head; the head starts a fresh slice after COMMIT.
                    state_d     = ST_COMMIT;
                    elem_cnt_d  = {WIDTH_LEN{1'b0}};
                    commit_no_d = cur_issue_q;
                end else begin
                    we_s   = 1'b1;
                    idx_s  = head_idx_s + WIDTH_IDX'(elem_cnt_q);
                    data_s = head_data_s;
                    if (I_RF_Ready) begin
                        cur_issue_d = head_issue_s;
                        if (elem_inc_s == eff_len_s) begin
                            state_d     = ST_COMMIT;
                            elem_cnt_d  = {WIDTH_LEN{1'b0}};
                            commit_no_d = head_issue_s;
                        end else begin
                            state_d    = ST_WRITE;
                            elem_cnt_d = elem_inc_s;
                        end
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_COMMIT: begin
                if (!empty_s || push_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer and slice registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            elem_cnt_q  <= {WIDTH_LEN{1'b0}};
            cur_issue_q <= {WIDTH_ISSUE{1'b0}};
            commit_no_q <= {WIDTH_ISSUE{1'b0}};
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            elem_cnt_q  <= elem_cnt_d;
            cur_issue_q <= cur_issue_d;
            commit_no_q <= commit_no_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {ENTRY_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= wb_entry_s;
            end else begin
                mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
            end
        end
    end

    assign O_Full      = full_s;
    assign O_RF_We     = we_s;
    assign O_RF_Idx    = idx_s;
    assign O_RF_Data   = data_s;
    assign O_Commit    = (state_q == ST_COMMIT);
    assign O_Commit_No = commit_no_q;
    assign O_Busy      = ~empty_s | (elem_cnt_q != {WIDTH_LEN{1'b0}}) | (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_commit_v.sv
// ---------------------------------------------------------------------------
// tb_wb_commit_v -- directed self-checking bench for wb_commit_v
// Default parameters: DEPTH 4, WIDTH_IDX 6, WIDTH_ISSUE 7, WIDTH_DATA 32.
// Outputs are sampled 1 time unit after each rising clock edge.
// Drained activity is recorded as events: 1000+idx for a write,
// 2000+issue for a commit, 9999 for a write coinciding with a commit.
// ---------------------------------------------------------------------------
module tb_wb_commit_v;

    logic        clock;
    logic        reset;
    logic        I_WB_Valid;
    logic [6:0]  I_WB_Issue_No;
    logic [5:0]  I_WB_Dst_Idx;
    logic [5:0]  I_WB_Slice_Len;
    logic [31:0] I_WB_Data;
    logic        I_RF_Ready;
    logic        O_Full;
    logic        O_RF_We;
    logic [5:0]  O_RF_Idx;
    logic [31:0] O_RF_Data;
    logic        O_Commit;
    logic [6:0]  O_Commit_No;
    logic        O_Busy;

    int n_cmp;
    int n_err;
    int ev_q[$];
    int dat_q[$];
    int exp_ev[$];
    int exp_dat[$];

    wb_commit_v #(
        .WIDTH_DATA (32),
        .WIDTH_ISSUE(7),
        .WIDTH_IDX  (6),
        .WIDTH_LEN  (6),
        .DEPTH      (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .I_WB_Valid    (I_WB_Valid),
        .I_WB_Issue_No (I_WB_Issue_No),
        .I_WB_Dst_Idx  (I_WB_Dst_Idx),
        .I_WB_Slice_Len(I_WB_Slice_Len),
        .I_WB_Data     (I_WB_Data),
        .I_RF_Ready    (I_RF_Ready),
        .O_Full        (O_Full),
        .O_RF_We       (O_RF_We),
        .O_RF_Idx      (O_RF_Idx),
        .O_RF_Data     (O_RF_Data),
        .O_Commit      (O_Commit),
        .O_Commit_No   (O_Commit_No),
        .O_Busy        (O_Busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_tok(input logic v, input int iss, input int idx, input int len, input int dat);
        I_WB_Valid     = v;
        I_WB_Issue_No  = 7'(iss);
        I_WB_Dst_Idx   = 6'(idx);
        I_WB_Slice_Len = 6'(len);
        I_WB_Data      = 32'(dat);
    endtask

    // Push one token over one clock edge, then drop valid.
    task automatic push_tok(input int iss, input int idx, input int len, input int dat);
        set_tok(1'b1, iss, idx, len, dat);
        tick();
        I_WB_Valid = 1'b0;
    endtask

    // Run with the current I_RF_Ready until the DUT is idle, recording events.
    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        ev_q.delete();
        dat_q.delete();
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (O_RF_We && O_Commit) begin
                ev_q.push_back(9999);
            end else if (O_RF_We && I_RF_Ready) begin
                ev_q.push_back(1000 + int'(O_RF_Idx));
                dat_q.push_back(int'(O_RF_Data));
            end else if (O_Commit) begin
                ev_q.push_back(2000 + int'(O_Commit_No));
            end
            if (!O_Busy) done = 1'b1;
            else tick();
        end
        chk({tag, "_drained"}, 32'(done), 32'd1);
    endtask

    task automatic cmp_events(input string tag);
        chk({tag, "_nev"}, 32'(ev_q.size()), 32'(exp_ev.size()));
        for (int i = 0; i < exp_ev.size(); i++) begin
            chk($sformatf("%s_ev%0d", tag, i), (i < ev_q.size()) ? 32'(ev_q[i]) : 32'hFFFF_FFFF, 32'(exp_ev[i]));
        end
        chk({tag, "_ndat"}, 32'(dat_q.size()), 32'(exp_dat.size()));
        for (int i = 0; i < exp_dat.size(); i++) begin
            chk($sformatf("%s_dat%0d", tag, i), (i < dat_q.size()) ? 32'(dat_q[i]) : 32'hFFFF_FFFF, 32'(exp_dat[i]));
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b0;
        I_RF_Ready = 1'b0;
        set_tok(1'b0, 0, 0, 0, 0);
        #2;
        chk("rst_we",     32'(O_RF_We),     32'd0);
        chk("rst_commit", 32'(O_Commit),    32'd0);
        chk("rst_no",     32'(O_Commit_No), 32'd0);
        chk("rst_full",   32'(O_Full),      32'd0);
        chk("rst_busy",   32'(O_Busy),      32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Single token: write the cycle after the push, commit the cycle after.
        I_RF_Ready = 1'b1;
        push_tok(5, 3, 1, 32'hA5);
        chk("t1_we",     32'(O_RF_We),   32'd1);
        chk("t1_idx",    32'(O_RF_Idx),  32'd3);
        chk("t1_data",   O_RF_Data,      32'hA5);
        chk("t1_nocmt",  32'(O_Commit),  32'd0);
        tick();
        chk("t1_commit", 32'(O_Commit),    32'd1);
        chk("t1_no",     32'(O_Commit_No), 32'd5);
        chk("t1_we_cmt", 32'(O_RF_We),     32'd0);
        tick();
        chk("t1_commit_once", 32'(O_Commit), 32'd0);
        chk("t1_idle",        32'(O_Busy),   32'd0);

        // Slice wrapping the index space: 62, 63, 0, 1.
        for (int i = 0; i < 4; i++) begin
            push_tok(9, 62, 4, 32'h900 + i);
            chk($sformatf("t2_we%0d", i),  32'(O_RF_We),  32'd1);
            chk($sformatf("t2_idx%0d", i), 32'(O_RF_Idx), 32'((62 + i) % 64));
            chk($sformatf("t2_dat%0d", i), O_RF_Data,     32'h900 + 32'(i));
            chk($sformatf("t2_nc%0d", i),  32'(O_Commit), 32'd0);
        end
        tick();
        chk("t2_commit", 32'(O_Commit),    32'd1);
        chk("t2_no",     32'(O_Commit_No), 32'd9);
        tick();
        chk("t2_idle", 32'(O_Busy), 32'd0);

        // Fill with the register file stalled; the fifth token is dropped.
        I_RF_Ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_notfull%0d", i), 32'(O_Full), 32'd0);
            push_tok(20, 10, 4, 32'h100 + i);
        end
        chk("t3_full", 32'(O_Full), 32'd1);
        set_tok(1'b1, 20, 10, 4, 32'hDEAD);
        chk("t3_drop_while_full", 32'(O_Full), 32'd1);
        tick();
        I_WB_Valid = 1'b0;
        chk("t3_full_hold", 32'(O_Full), 32'd1);
        chk("t3_held_idx",  32'(O_RF_Idx), 32'd10);
        I_RF_Ready = 1'b1;
        drain("t3");
        exp_ev  = '{1010, 1011, 1012, 1013, 2020};
        exp_dat = '{32'h100, 32'h101, 32'h102, 32'h103};
        cmp_events("t3");

        // Push and pop together at DEPTH-1 keeps the count at DEPTH-1.
        I_RF_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_tok(30, 0, 4, 32'h300 + i);
        end
        chk("t4_three_notfull", 32'(O_Full), 32'd0);
        I_RF_Ready = 1'b1;
        push_tok(30, 0, 4, 32'h303);
        I_RF_Ready = 1'b0;
        chk("t4_pushpop_notfull", 32'(O_Full), 32'd0);
        push_tok(31, 40, 1, 32'h310);
        chk("t4_then_full", 32'(O_Full), 32'd1);
        I_RF_Ready = 1'b1;
        drain("t4");
        exp_ev  = '{1001, 1002, 1003, 2030, 1040, 2031};
        exp_dat = '{32'h301, 32'h302, 32'h303, 32'h310};
        cmp_events("t4");

        // Incomplete slice closed by a new issue number without writing it.
        I_RF_Ready = 1'b0;
        push_tok(2, 5, 3, 32'h200);
        push_tok(2, 5, 3, 32'h201);
        push_tok(3, 20, 1, 32'h320);
        I_RF_Ready = 1'b1;
        drain("t5");
        exp_ev  = '{1005, 1006, 2002, 1020, 2003};
        exp_dat = '{32'h200, 32'h201, 32'h320};
        cmp_events("t5");

        // Reset in the middle of a slice discards it with no commit.
        I_RF_Ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_tok(40, 0, 4, 32'h400 + i);
        end
        I_RF_Ready = 1'b1;
        tick();
        tick();
        chk("t6_mid_idx", 32'(O_RF_Idx), 32'd2);
        reset = 1'b0;
        #1;
        chk("t6_rst_we",     32'(O_RF_We),     32'd0);
        chk("t6_rst_commit", 32'(O_Commit),    32'd0);
        chk("t6_rst_no",     32'(O_Commit_No), 32'd0);
        chk("t6_rst_full",   32'(O_Full),      32'd0);
        chk("t6_rst_busy",   32'(O_Busy),      32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("t6_post_commit", 32'(O_Commit), 32'd0);
        chk("t6_post_busy",   32'(O_Busy),   32'd0);
        // Slice length 0 behaves as a single element.
        push_tok(7, 9, 0, 32'h77);
        drain("t6");
        exp_ev  = '{1009, 2007};
        exp_dat = '{32'h77};
        cmp_events("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
